// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and sizing helpers for the fifo_umbrales bank.
package fifo_pkg;
  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH = 1 << ADDR_W_DEF;
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_umbrales_memoria_dual.sv
// memoria_dual: simple dual-port register file, synchronous write, registered synchronous read.
module memoria_dual #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: synchronous FIFO with almost-empty/almost-full thresholds and sticky error flag.
// Define FIFO_PEAK_EN to add the registered high-water mark output peak.
module fifo_umbrales
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic [7:0]        bajo,
  input  logic [7:0]        alto,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
`ifdef FIFO_PEAK_EN
  output logic [ADDR_W:0]   peak,
`endif
  output logic              error_out
);
  localparam int CW = cnt_w(ADDR_W);
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic push_ok, pop_ok;
  assign empty = count == '0;
  assign full = count == DEPTH_C;
  assign almost_empty = 8'(count) <= bajo;
  assign almost_full = 8'(count) >= alto;
  assign push_ok = push && (!full || pop);
  assign pop_ok = pop && !empty;
  assign count_nx = push_ok && !pop_ok ? count + CW'(1) :
                    !push_ok && pop_ok ? count - CW'(1) : count;
  memoria_dual #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .reset(reset),
    .we(push_ok), .wa(wr_ptr), .wd(data_in),
    .re(pop_ok), .ra(rd_ptr), .rd(data_out)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + ADDR_W'(1) : rd_ptr;
      count <= count_nx;
      valid_out <= pop_ok;
      error_out <= error_out || (push && full && !pop) || (pop && empty);
    end
`ifdef FIFO_PEAK_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) peak <= '0;
    else if (count_nx > peak) peak <= count_nx;
`endif
endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: directed self-checking bench for fifo_umbrales (depth 8, 6-bit data).
module tb_fifo_umbrales;
  logic clk = 0, reset = 0, push = 0, pop = 0;
  logic [5:0] data_in = '0, data_out;
  logic [7:0] bajo = 8'd2, alto = 8'd6;
  logic valid_out, empty, full, almost_empty, almost_full, error_out;
`ifdef FIFO_PEAK_EN
  logic [3:0] peak;
`endif
  int errors = 0, checks = 0;

  fifo_umbrales dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .bajo(bajo), .alto(alto),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
`ifdef FIFO_PEAK_EN
    .peak(peak),
`endif
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    reset = 0;
    #2;
    reset = 1;
    tick();
  endtask

  task automatic fill(input logic [5:0] base);
    push = 1;
    for (int i = 0; i < 8; i++) begin
      data_in = base + 6'(i);
      tick();
    end
    push = 0;
  endtask

  task automatic drain_chk(input string tag, input logic [5:0] base, input int n);
    pop = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {26'd0, data_out}, {26'd0, base + 6'(i)});
      chk({tag, "_valid"}, {31'd0, valid_out}, 1);
    end
    pop = 0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_ae", {31'd0, almost_empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_af", {31'd0, almost_full}, 0);
    chk("rst_err", {31'd0, error_out}, 0);
    chk("rst_valid", {31'd0, valid_out}, 0);
    reset = 1;
    tick();
    tick();
    chk("idle_empty", {31'd0, empty}, 1);
    chk("idle_valid", {31'd0, valid_out}, 0);
    chk("idle_err", {31'd0, error_out}, 0);
    alto = 8'd0;
    #1;
    chk("alto0_af", {31'd0, almost_full}, 1);
    alto = 8'd6;
    #1;
    chk("alto6_af", {31'd0, almost_full}, 0);

    push = 1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 6'(i);
      tick();
      chk("fill_ae", {31'd0, almost_empty}, {31'd0, i <= 2});
      chk("fill_af", {31'd0, almost_full}, {31'd0, i >= 6});
      chk("fill_full", {31'd0, full}, {31'd0, i == 8});
    end
    push = 0;
    bajo = 8'd8;
    #1;
    chk("bajo8_ae", {31'd0, almost_empty}, 1);
    bajo = 8'd2;
    #1;
    chk("bajo2_ae", {31'd0, almost_empty}, 0);
    chk("pre_drain_valid", {31'd0, valid_out}, 0);
    drain_chk("drain1", 6'h01, 8);
    tick();
    chk("drain1_valid_off", {31'd0, valid_out}, 0);
    chk("drain1_empty", {31'd0, empty}, 1);
    chk("drain1_hold", {26'd0, data_out}, 32'h08);

    fill(6'h11);
    push = 1;
    pop = 1;
    data_in = 6'h2A;
    tick();
    push = 0;
    pop = 0;
    chk("pp_full", {31'd0, full}, 1);
    chk("pp_data", {26'd0, data_out}, 32'h11);
    chk("pp_valid", {31'd0, valid_out}, 1);
    chk("pp_err", {31'd0, error_out}, 0);
    drain_chk("pp_drain", 6'h12, 7);
    pop = 1;
    tick();
    pop = 0;
    chk("pp_tail", {26'd0, data_out}, 32'h2A);
    chk("pp_empty", {31'd0, empty}, 1);
    chk("pp_err2", {31'd0, error_out}, 0);

    fill(6'h31);
    push = 1;
    data_in = 6'h3F;
    tick();
    push = 0;
    chk("ovf_err", {31'd0, error_out}, 1);
    chk("ovf_full", {31'd0, full}, 1);
    tick();
    chk("ovf_sticky", {31'd0, error_out}, 1);
    drain_chk("ovf_drain", 6'h31, 8);
    chk("ovf_empty", {31'd0, empty}, 1);

    reset_pulse();
    chk("unf_pre_err", {31'd0, error_out}, 0);
    pop = 1;
    tick();
    pop = 0;
    chk("unf_err", {31'd0, error_out}, 1);
    chk("unf_valid", {31'd0, valid_out}, 0);
    reset_pulse();
    pop = 1;
    push = 1;
    data_in = 6'h15;
    tick();
    push = 0;
    pop = 0;
    chk("unfp_err", {31'd0, error_out}, 1);
    chk("unfp_valid", {31'd0, valid_out}, 0);
    chk("unfp_empty", {31'd0, empty}, 0);
    pop = 1;
    tick();
    pop = 0;
    chk("unfp_data", {26'd0, data_out}, 32'h15);
    chk("unfp_rvalid", {31'd0, valid_out}, 1);
    chk("unfp_empty2", {31'd0, empty}, 1);

    reset_pulse();
    push = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = 6'h01 + 6'(i);
      tick();
    end
    push = 0;
    drain_chk("wrap_a", 6'h01, 5);
    push = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = 6'h21 + 6'(i);
      tick();
    end
    push = 0;
    chk("wrap_err", {31'd0, error_out}, 0);
    drain_chk("wrap_b", 6'h21, 3);
    chk("wrap_ae", {31'd0, almost_empty}, 1);
`ifdef FIFO_PEAK_EN
    chk("peak_pre", {28'd0, peak}, 5);
`endif
    reset = 0;
    #1;
    chk("arst_empty", {31'd0, empty}, 1);
    chk("arst_full", {31'd0, full}, 0);
    chk("arst_valid", {31'd0, valid_out}, 0);
    chk("arst_data", {26'd0, data_out}, 0);
    chk("arst_ae", {31'd0, almost_empty}, 1);
    chk("arst_af", {31'd0, almost_full}, 0);
`ifdef FIFO_PEAK_EN
    chk("peak_post", {28'd0, peak}, 0);
`endif
    tick();
    reset = 1;
    tick();
    push = 1;
    data_in = 6'h36;
    tick();
    push = 0;
    pop = 1;
    tick();
    pop = 0;
    chk("post_data", {26'd0, data_out}, 32'h36);
    chk("post_valid", {31'd0, valid_out}, 1);
    chk("post_empty", {31'd0, empty}, 1);
    chk("post_err", {31'd0, error_out}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_umbrales.md
Name: fifo_umbrales

Overview:
- Single-clock synchronous FIFO with programmable almost-empty/almost-full thresholds.
- Eight instances form the FIFO bank next to the flow-control state machine.
- The bank's `empty` outputs form that machine's 8-bit `empty_fifos` vector.
- The machine's `bajo_out`/`alto_out` drive `bajo`/`alto` here; flags give backpressure/pause to producer and consumer logic.

Parameters:
- DATA_W, 6, data word width.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- Constraint: ADDR_W ≤ 7, so that the count range 0..2**ADDR_W fits in 8 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- push  in  1  write request.
- data_in  in  DATA_W  write data.
- pop  in  1  read request.
- data_out  out  DATA_W  read data, registered.
- valid_out  out  1  data_out holds a word popped in the previous cycle.
- bajo  in  8  almost-empty threshold (from the state machine's bajo_out).
- alto  in  8  almost-full threshold (from the state machine's alto_out).
- empty  out  1  count == 0.
- full  out  1  count == 2**ADDR_W.
- almost_empty  out  1  count ≤ bajo.
- almost_full  out  1  count ≥ alto.
- error_out  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset==0, asynchronous):
  - wr_ptr, rd_ptr, count, data_out, valid_out and error_out are all 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- State: wr_ptr, rd_ptr (ADDR_W bits, wrap modulo depth) and count (ADDR_W+1 bits). All flags derive from count.
- Qualification, per cycle:
  - A push is accepted when push && (!full || pop).
  - A pop is accepted when pop && !empty.
- Accepted push: mem[wr_ptr] ← data_in; wr_ptr increments and wraps from 2**ADDR_W−1 to 0.
- Accepted pop:
  - data_out ← mem[rd_ptr] at the clock edge; valid_out=1 in the following cycle.
  - rd_ptr increments and wraps.
  - Read latency is one cycle.
- valid_out is 0 in any cycle not following an accepted pop. data_out holds its last value.
- Count update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Simultaneous push and pop:
  - When full, both are accepted; the popped word is the oldest, and count stays at depth.
  - When empty, only the push is accepted; the pop is an underflow.
  - No write-to-read bypass: a word pushed into an empty FIFO is poppable from the next cycle.
- Flags are combinational from registered count, so they are valid in the same cycle as count.
  - Threshold compares zero-extend count to 8 bits.
  - bajo ≥ depth forces almost_empty=1.
  - alto=0 forces almost_full=1.
  - Thresholds may change on any cycle; flags follow immediately.
- Errors:
  - Overflow: push && full && !pop. Data is dropped and pointers are unchanged.
  - Underflow: pop && empty. No read, valid_out=0.
  - Either sets error_out=1, which holds until reset.
- Reset asserted mid-operation discards all contents; the next push after release lands at address 0.

Optional Feature:
- Macro FIFO_PEAK_EN.
- Defined:
  - Adds output `peak` (ADDR_W+1 bits), a registered high-water mark of count.
  - Each cycle, peak ← max(peak, next count); reset value 0.
  - Cleared only by reset.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_W/ADDR_W
  - localparam DEPTH = 1<<ADDR_W
  - the count width function
- Sub-module memoria_dual:
  - Simple dual-port register file.
  - One synchronous write port and one synchronous read port with registered output.
  - fifo_umbrales keeps pointers, count, flags and errors.

Test Plan:
- Reset then idle:
  - empty=1, almost_empty=1, full=0, almost_full=0, error_out=0, valid_out=0.
  - Releasing reset changes nothing until a push.
- bajo=2, alto=6, depth 8; push 0x01..0x08 on consecutive cycles:
  - almost_empty drops when count reaches 3; almost_full rises at count 6; full=1 at count 8.
  - Then 8 pops return 0x01..0x08 in order, each with valid_out one cycle after its pop.
- Full FIFO; assert push+pop together with data_in=0x2A:
  - count stays 8; data_out = oldest word.
  - 0x2A appears after the 7 remaining words; error_out=0.
- Full FIFO; push without pop:
  - error_out=1 next cycle and stays 1.
  - Contents unchanged (verified by draining).
- Empty FIFO; pop, and separately pop+push of 0x15:
  - Underflow sets error_out; valid_out stays 0.
  - 0x15 is readable on the next pop.
- Wrap-around and reset: push 5, pop 5, push 5 (pointers wrap), assert reset mid-stream:
  - All outputs return to reset values asynchronously.
  - The next push/pop round-trips correctly.
  - With FIFO_PEAK_EN, peak=5 before the reset and 0 after it.
